rf_write_queue: RTL and testbench

- Write-side front end for the 32x32 register file; owns the regfile write port (we3/wa3/wd3).
- Accepts write-back requests from two producers: src0 (main pipeline WB) and src1 (multi-cycle mult/div unit).
- Buffers the requests in a small FIFO and retires exactly one write per cycle to the register file.
- Provides a two-port bypass lookup so decode can see writes that have not yet landed in the register file.

---
 rtl/rf_pkg.sv | 11 +
 rtl/rf_wq_match.sv | 29 ++
 rtl/rf_write_queue.sv | 136 +++++++++++++
 tb/tb_rf_write_queue.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths and write-request type for the register-file write queue
package rf_pkg;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } rf_wreq_t;
endpackage

// File: rtl/rf_wq_match.sv
// rtl/rf_wq_match.sv - newest-first address match over pending register writes
// Candidate 0 is the newest; the lowest matching index wins.
module rf_wq_match
  import rf_pkg::*;
#(
  parameter int N  = 5,
  parameter int AW = rf_pkg::AW,
  parameter int DW = rf_pkg::DW
) (
  input  logic [AW-1:0]         ra_i,
  input  logic [N-1:0]          vld_i,
  input  logic [N-1:0][AW-1:0]  wa_i,
  input  logic [N-1:0][DW-1:0]  wd_i,
  output logic                  hit_o,
  output logic [DW-1:0]         rd_o
);

  always_comb begin
    hit_o = 1'b0;
    rd_o  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vld_i[i] && (wa_i[i] == ra_i) && (ra_i != '0)) begin
        hit_o = 1'b1;
        rd_o  = wd_i[i];
      end
    end
  end

endmodule

// File: rtl/rf_write_queue.sv
// rtl/rf_write_queue.sv - two-producer write-back FIFO driving the regfile write port
// Retires one write per cycle and exposes pending writes through a two-port bypass.
module rf_write_queue
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = rf_pkg::AW,
  parameter int DW    = rf_pkg::DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s0_valid,
  output logic                     s0_ready,
  input  logic [AW-1:0]            s0_wa,
  input  logic [DW-1:0]            s0_wd,
  input  logic                     s1_valid,
  output logic                     s1_ready,
  input  logic [AW-1:0]            s1_wa,
  input  logic [DW-1:0]            s1_wd,
  output logic                     we3,
  output logic [AW-1:0]            wa3,
  output logic [DW-1:0]            wd3,
  input  logic [AW-1:0]            q_ra1,
  input  logic [AW-1:0]            q_ra2,
  output logic                     q_hit1,
  output logic                     q_hit2,
  output logic [DW-1:0]            q_rd1,
  output logic [DW-1:0]            q_rd2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] mem_wa_q [DEPTH];
  logic [DW-1:0] mem_wd_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, s1_ptr;
  logic [CW-1:0] count_q, count_d, free;
  logic          we3_q;
  logic [AW-1:0] wa3_q;
  logic [DW-1:0] wd3_q;
  logic          pop, s0_needy, s0_store, s1_store;

  assign pop      = (count_q != '0);
  assign free     = CW'(DEPTH) - count_q + CW'(pop);
  assign s0_needy = s0_valid && (s0_wa != '0);

  // Ready is withheld during reset so nothing is accepted on the reset edge.
  assign s0_ready = !rst && (free >= CW'(1));
  assign s1_ready = !rst && (free >= (CW'(1) + CW'(s0_needy)));

  assign s0_store = s0_valid && s0_ready && (s0_wa != '0);
  assign s1_store = s1_valid && s1_ready && (s1_wa != '0);
  assign s1_ptr   = wr_ptr_q + PW'(s0_store);

  assign count_d  = count_q - CW'(pop) + CW'(s0_store) + CW'(s1_store);
  assign wr_ptr_d = wr_ptr_q + PW'(s0_store) + PW'(s1_store);
  assign rd_ptr_d = rd_ptr_q + PW'(pop);

  always_ff @(posedge clk) begin
    if (s0_store) begin
      mem_wa_q[wr_ptr_q] <= s0_wa;
      mem_wd_q[wr_ptr_q] <= s0_wd;
    end
    if (s1_store) begin
      mem_wa_q[s1_ptr] <= s1_wa;
      mem_wd_q[s1_ptr] <= s1_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      we3_q    <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      we3_q    <= pop;
      if (pop) begin
        wa3_q <= mem_wa_q[rd_ptr_q];
        wd3_q <= mem_wd_q[rd_ptr_q];
      end
    end
  end

  assign we3   = we3_q;
  assign wa3   = wa3_q;
  assign wd3   = wd3_q;
  assign count = count_q;

  // Candidates newest first: tail-1 down to head, then the output stage last.
  logic [DEPTH:0]         cand_vld;
  logic [DEPTH:0][AW-1:0] cand_wa;
  logic [DEPTH:0][DW-1:0] cand_wd;

  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    cand_vld = '0;
    cand_wa  = '0;
    cand_wd  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx         = wr_ptr_q - PW'(i + 1);
      cand_vld[i] = (CW'(i) < count_q);
      cand_wa[i]  = mem_wa_q[idx];
      cand_wd[i]  = mem_wd_q[idx];
    end
    cand_vld[DEPTH] = we3_q;
    cand_wa[DEPTH]  = wa3_q;
    cand_wd[DEPTH]  = wd3_q;
  end

  rf_wq_match #(.N(DEPTH + 1), .AW(AW), .DW(DW)) u_match1 (
    .ra_i  (q_ra1),
    .vld_i (cand_vld),
    .wa_i  (cand_wa),
    .wd_i  (cand_wd),
    .hit_o (q_hit1),
    .rd_o  (q_rd1)
  );

  rf_wq_match #(.N(DEPTH + 1), .AW(AW), .DW(DW)) u_match2 (
    .ra_i  (q_ra2),
    .vld_i (cand_vld),
    .wa_i  (cand_wa),
    .wd_i  (cand_wd),
    .hit_o (q_hit2),
    .rd_o  (q_rd2)
  );

endmodule

// File: tb/tb_rf_write_queue.sv
// tb/tb_rf_write_queue.sv - self-checking bench for rf_write_queue against a queue-level model
module tb_rf_write_queue;
  import rf_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        s0_valid, s1_valid, s0_ready, s1_ready;
  logic [4:0]  s0_wa, s1_wa, wa3, q_ra1, q_ra2;
  logic [31:0] s0_wd, s1_wd, wd3, q_rd1, q_rd2;
  logic        we3, q_hit1, q_hit2;
  logic [2:0]  count;

  always #5 clk = ~clk;

  rf_write_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_wa(s0_wa), .s0_wd(s0_wd),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_wa(s1_wa), .s1_wd(s1_wd),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .q_ra1(q_ra1), .q_ra2(q_ra2),
    .q_hit1(q_hit1), .q_hit2(q_hit2), .q_rd1(q_rd1), .q_rd2(q_rd2),
    .count(count)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a plain queue of pending writes plus the output stage.
  rf_wreq_t    mq[$];
  logic        exp_we = 1'b0;
  logic [4:0]  exp_wa = '0;
  logic [31:0] exp_wd = '0;
  bit          m_acc0, m_acc1, chk_en;
  int          pushed = 0, retired = 0, discarded = 0;
  logic [31:0] rf_arr [32];
  bit          r0_written = 1'b0;

  initial for (int i = 0; i < 32; i++) rf_arr[i] = '0;

  always @(posedge clk) begin : model
    int n, fr;
    rf_wreq_t e;
    if (rst) begin
      discarded += mq.size();
      mq.delete();
      exp_we = 1'b0; exp_wa = '0; exp_wd = '0;
      m_acc0 = 1'b0; m_acc1 = 1'b0;
    end else begin
      n  = mq.size();
      fr = DEPTH - n + ((n != 0) ? 1 : 0);
      m_acc0 = s0_valid && (fr >= 1);
      m_acc1 = s1_valid && (fr >= 1 + ((s0_valid && s0_wa != 0) ? 1 : 0));
      if (n != 0) begin
        e = mq.pop_front();
        exp_we = 1'b1; exp_wa = e.wa; exp_wd = e.wd;
      end else begin
        exp_we = 1'b0;
      end
      if (m_acc0 && s0_wa != 0) begin mq.push_back('{wa: s0_wa, wd: s0_wd}); pushed++; end
      if (m_acc1 && s1_wa != 0) begin mq.push_back('{wa: s1_wa, wd: s1_wd}); pushed++; end
    end
  end

  always @(negedge clk) begin
    if (we3) begin
      rf_arr[wa3] <= wd3;
      if (wa3 == 5'd0) r0_written <= 1'b1;
    end
  end

  function automatic void lookup(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0; d = '0;
    if (a != 0) begin
      if (exp_we && exp_wa == a) begin h = 1'b1; d = exp_wd; end
      foreach (mq[i]) if (mq[i].wa == a) begin h = 1'b1; d = mq[i].wd; end
    end
  endfunction

  always @(negedge clk) begin : compare
    int n, fr;
    logic h1, h2;
    logic [31:0] d1, d2;
    #4;
    if (chk_en) begin
      n  = mq.size();
      fr = DEPTH - n + ((n != 0) ? 1 : 0);
      if (!rst) begin
        chk("cyc_s0_ready", s0_ready, fr >= 1);
        chk("cyc_s1_ready", s1_ready, fr >= 1 + ((s0_valid && s0_wa != 0) ? 1 : 0));
      end
      chk("cyc_count", count, n);
      chk("cyc_we3", we3, exp_we);
      if (exp_we) begin
        chk("cyc_wa3", wa3, exp_wa);
        chk("cyc_wd3", wd3, exp_wd);
      end
      lookup(q_ra1, h1, d1);
      lookup(q_ra2, h2, d2);
      chk("cyc_hit1", q_hit1, h1);
      chk("cyc_rd1", q_rd1, d1);
      chk("cyc_hit2", q_hit2, h2);
      chk("cyc_rd2", q_rd2, d2);
      if (we3) retired++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    s0_valid = 0; s0_wa = 0; s0_wd = 0;
    s1_valid = 0; s1_wa = 0; s1_wd = 0;
    q_ra1 = 0; q_ra2 = 0;
    chk_en = 1'b0;
    tick(); tick();
    rst = 1'b0; chk_en = 1'b1;
    settle();
    chk("rst_count", count, 0);
    chk("rst_we3", we3, 0);
    chk("rst_wa3", wa3, 0);
    chk("rst_wd3", wd3, 0);
    chk("rst_hit1", q_hit1, 0);

    // Single write r5 = DEADBEEF
    tick(); s0_valid = 1; s0_wa = 5; s0_wd = 32'hDEADBEEF;
    tick(); s0_valid = 0; settle();
    chk("single_count1", count, 1);
    chk("single_we3_0", we3, 0);
    tick(); settle();
    chk("single_we3", we3, 1);
    chk("single_wa3", wa3, 5);
    chk("single_wd3", wd3, 32'hDEADBEEF);
    chk("single_count0", count, 0);
    chk("single_rf5", rf_arr[5], 32'hDEADBEEF);

    // Dual enqueue: s0 before s1
    tick(); s0_valid = 1; s0_wa = 3; s0_wd = 32'h11; s1_valid = 1; s1_wa = 4; s1_wd = 32'h22;
    settle();
    chk("dual_s0_ready", s0_ready, 1);
    chk("dual_s1_ready", s1_ready, 1);
    tick(); s0_valid = 0; s1_valid = 0; settle();
    chk("dual_count", count, 2);
    tick(); settle();
    chk("dual_first_wa", wa3, 3);
    chk("dual_first_wd", wd3, 32'h11);
    tick(); settle();
    chk("dual_second_wa", wa3, 4);
    chk("dual_second_wd", wd3, 32'h22);
    tick(); settle();
    chk("dual_idle_we3", we3, 0);

    // Bypass newest-wins
    tick(); s0_valid = 1; s0_wa = 9; s0_wd = 32'h1; q_ra1 = 9; q_ra2 = 0;
    tick(); s0_wd = 32'h2;
    tick(); s0_valid = 0; settle();
    chk("byp_hit1", q_hit1, 1);
    chk("byp_rd1", q_rd1, 32'h2);
    chk("byp_hit2_r0", q_hit2, 0);
    tick(); settle();
    chk("byp_out_hit1", q_hit1, 1);
    chk("byp_out_rd1", q_rd1, 32'h2);
    tick(); settle();
    chk("byp_done_hit1", q_hit1, 0);
    chk("byp_done_rd1", q_rd1, 0);

    // Fill to DEPTH, then backpressure and r0 drop
    for (int k = 0; k < 3; k++) begin
      tick();
      s0_valid = 1; s0_wa = 5'(10 + 2 * k); s0_wd = 32'(16'hA0 + k);
      s1_valid = 1; s1_wa = 5'(11 + 2 * k); s1_wd = 32'(16'hB0 + k);
    end
    tick(); s0_wa = 16; s0_wd = 32'hA3; s1_wa = 17; s1_wd = 32'hB3;
    settle();
    chk("bp_count_full", count, DEPTH);
    chk("bp_s0_ready", s0_ready, 1);
    chk("bp_s1_ready", s1_ready, 0);
    tick(); s0_valid = 0; settle();
    chk("bp_s1_held_ready", s1_ready, 1);
    chk("bp_count_after", count, DEPTH);
    tick(); s0_valid = 1; s0_wa = 0; s0_wd = 32'h55; s1_wa = 7; s1_wd = 32'h66;
    settle();
    chk("r0_s0_ready", s0_ready, 1);
    chk("r0_s1_ready", s1_ready, 1);
    tick(); s0_valid = 0; s1_valid = 0; settle();
    chk("r0_count", count, DEPTH);
    for (int k = 0; k < 20 && (count != 0 || we3); k++) tick();
    settle();
    chk("r0_drained", count, 0);
    chk("r0_never_written", r0_written, 0);
    chk("r7_written", rf_arr[7], 32'h66);

    // Reset mid-queue with r5 pending
    tick(); s0_valid = 1; s0_wa = 6; s0_wd = 32'h66; s1_valid = 1; s1_wa = 7; s1_wd = 32'h77;
    tick(); s0_wa = 5; s0_wd = 32'hAAAA; s1_wa = 8; s1_wd = 32'h88;
    tick(); s0_valid = 0; s1_valid = 0; settle();
    chk("midrst_count3", count, 3);
    rst = 1'b1;
    tick(); rst = 1'b0; settle();
    chk("midrst_count0", count, 0);
    chk("midrst_we3", we3, 0);
    tick(); settle();
    chk("midrst_rf5_kept", rf_arr[5], 32'hDEADBEEF);

    // Random traffic, sources hold until accepted
    for (int c = 0; c < 100; c++) begin
      tick();
      if (!s0_valid || m_acc0) begin
        s0_valid = 1'($urandom_range(0, 1)); s0_wa = 5'($urandom_range(0, 15)); s0_wd = $urandom;
      end
      if (!s1_valid || m_acc1) begin
        s1_valid = 1'($urandom_range(0, 1)); s1_wa = 5'($urandom_range(0, 15)); s1_wd = $urandom;
      end
      q_ra1 = 5'($urandom_range(0, 15));
      q_ra2 = 5'($urandom_range(0, 15));
    end
    tick(); s0_valid = 0; s1_valid = 0;
    for (int k = 0; k < 20 && (count != 0 || we3); k++) tick();
    tick(); settle();
    chk("rand_drain_count", count, 0);
    chk("rand_drain_we3", we3, 0);
    chk("rand_no_loss_dup", retired, pushed - discarded);
    chk("rand_r0_never", r0_written, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
